// File: rtl/irda_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : irda_tx_scheduler_pkg
// Brief   : Shared state encoding and width helpers for the IrDA TX scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package irda_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_LOAD    = 3'd2,
        S_SEND    = 3'd3,
        S_WAIT_LO = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;

    // Channel index width; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold the value max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/irda_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : irda_tx_scheduler_if
// Brief   : FIFO-side and transmitter-side signal bundle of the TX scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface irda_tx_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CH_W   = irda_tx_scheduler_pkg::idx_width(NUM_CH)
);
    logic [NUM_CH-1:0]        fifo_empty;
    logic [NUM_CH*DATA_W-1:0] fifo_data;
    logic [NUM_CH-1:0]        fifo_rd;
    logic                     rx_idle;
    logic                     ir_tx_idle;
    logic                     tx_ready;
    logic [DATA_W-1:0]        tx_data;
    logic                     send;
    logic [CH_W-1:0]          active_ch;
    logic                     busy;

    modport master (
        input  fifo_empty, fifo_data, rx_idle, ir_tx_idle, tx_ready,
        output fifo_rd, tx_data, send, active_ch, busy
    );

    modport slave (
        output fifo_empty, fifo_data, rx_idle, ir_tx_idle, tx_ready,
        input  fifo_rd, tx_data, send, active_ch, busy
    );
endinterface
`default_nettype wire

// File: rtl/irda_tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : irda_tx_scheduler_rr_arbiter
// Brief   : Combinational round-robin pick, searching upward from last grant.
// Revision: 1.0 - initial release
// ============================================================================
module irda_tx_scheduler_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  wire logic [NUM_CH-1:0] i_req,
    input  wire logic [CH_W-1:0]   i_last_grant,
    output logic      [CH_W-1:0]   o_grant,
    output logic                   o_grant_valid
);

    always_comb begin
        int w_idx;
        w_idx         = 0;
        o_grant       = '0;
        o_grant_valid = 1'b0;
        // Offset NUM_CH wraps back to last_grant itself, so it has lowest priority.
        for (int off = 1; off <= NUM_CH; off++) begin
            w_idx = (int'(i_last_grant) + off) % NUM_CH;
            for (int j = 0; j < NUM_CH; j++) begin
                if (!o_grant_valid && (j == w_idx) && i_req[j]) begin
                    o_grant       = CH_W'(j);
                    o_grant_valid = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irda_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : irda_tx_scheduler
// Brief   : Round-robin multi-FIFO feeder for a half-duplex IrDA transmitter.
// Revision: 1.0 - initial release
// ============================================================================
module irda_tx_scheduler
    import irda_tx_scheduler_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int GUARD_CYC = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    irda_tx_scheduler_if.master  bus
);

    localparam int c_ch_w = idx_width(NUM_CH);
    localparam int c_bw   = cnt_width(MAX_BURST);
    localparam int c_gw   = cnt_width(GUARD_CYC);

    state_t              r_state,      w_state_nxt;
    logic [c_ch_w-1:0]   r_active_ch,  w_active_ch_nxt;
    logic [c_ch_w-1:0]   r_last_grant, w_last_grant_nxt;
    logic [c_bw-1:0]     r_burst_cnt,  w_burst_cnt_nxt;
    logic [DATA_W-1:0]   r_tx_data,    w_tx_data_nxt;
    logic [c_gw-1:0]     r_guard;

    logic [c_ch_w-1:0]   w_grant;
    logic                w_grant_valid;
    logic                w_medium_ok;
    logic                w_sel_empty;
    logic [DATA_W-1:0]   w_sel_data;
    logic [NUM_CH-1:0]   w_fifo_rd;

    irda_tx_scheduler_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (c_ch_w)
    ) u_arb (
        .i_req         (~bus.fifo_empty),
        .i_last_grant  (r_last_grant),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    // Any receive activity restarts the quiet period before we may transmit.
    always_ff @(posedge clk) begin
        if (rst || !bus.rx_idle) begin
            r_guard <= c_gw'(GUARD_CYC);
        end else if (r_guard != '0) begin
            r_guard <= r_guard - c_gw'(1);
        end
    end

    assign w_medium_ok = bus.rx_idle && bus.ir_tx_idle && (r_guard == '0);

    always_comb begin
        w_sel_empty = 1'b1;
        w_sel_data  = '0;
        w_fifo_rd   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_active_ch == c_ch_w'(i)) begin
                w_sel_empty  = bus.fifo_empty[i];
                w_sel_data   = bus.fifo_data[i*DATA_W +: DATA_W];
                w_fifo_rd[i] = (r_state == S_READ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_active_ch  <= '0;
            r_last_grant <= c_ch_w'(NUM_CH - 1);
            r_burst_cnt  <= '0;
            r_tx_data    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_active_ch  <= w_active_ch_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
            r_tx_data    <= w_tx_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_active_ch_nxt  = r_active_ch;
        w_last_grant_nxt = r_last_grant;
        w_burst_cnt_nxt  = r_burst_cnt;
        w_tx_data_nxt    = r_tx_data;
        unique case (r_state)
            S_IDLE: begin
                if (w_medium_ok && bus.tx_ready && w_grant_valid) begin
                    w_active_ch_nxt = w_grant;
                    w_burst_cnt_nxt = '0;
                    w_state_nxt     = S_READ;
                end
            end
            S_READ:    w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_tx_data_nxt = w_sel_data;
                w_state_nxt   = S_SEND;
            end
            S_SEND: begin
                w_burst_cnt_nxt = r_burst_cnt + c_bw'(1);
                w_state_nxt     = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!bus.tx_ready) w_state_nxt = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                // The in-flight word is finished; only continue if the medium is still clear.
                if (bus.tx_ready) begin
                    if ((r_burst_cnt < c_bw'(MAX_BURST)) && !w_sel_empty && w_medium_ok) begin
                        w_state_nxt = S_READ;
                    end else begin
                        w_last_grant_nxt = r_active_ch;
                        w_state_nxt      = S_IDLE;
                    end
                end
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.fifo_rd   = w_fifo_rd;
    assign bus.send      = (r_state == S_SEND);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.tx_data   = r_tx_data;
    assign bus.active_ch = r_active_ch;

endmodule
`default_nettype wire

// File: tb/tb_irda_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_irda_tx_scheduler
// Brief   : Scoreboard bench with FIFO and transmitter models for the scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_irda_tx_scheduler;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;
    localparam int GUARD_CYC = 16;
    localparam int CH_W      = 2;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    irda_tx_scheduler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) bus ();

    irda_tx_scheduler #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST),
        .GUARD_CYC (GUARD_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t              exp_q [$];
    logic [DATA_W-1:0] fq    [NUM_CH][$];
    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int send_cnt = 0;
    int rd_cnt   = 0;
    int lo_cnt   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO + transmitter models and the scoreboard monitor, all at negedge.
    always @(negedge clk) begin
        int rd_ch;
        logic [DATA_W-1:0] d;
        exp_t e;
        rd_ch = 0;
        if (bus.fifo_rd != '0) begin
            for (int i = 0; i < NUM_CH; i++) if (bus.fifo_rd[i]) rd_ch = i;
            rd_cnt++;
            total++;
            if (!$onehot(bus.fifo_rd) || fq[rd_ch].size() == 0) begin
                bad++;
                $display("FAIL rd_legal: fifo_rd=%b target_words=%0d, want one-hot read of non-empty fifo",
                         bus.fifo_rd, fq[rd_ch].size());
            end
            if (fq[rd_ch].size() != 0) begin
                d = fq[rd_ch].pop_front();
                for (int i = 0; i < NUM_CH; i++)
                    if (i == rd_ch) bus.fifo_data[i*DATA_W +: DATA_W] = d;
            end
        end
        if (bus.send) begin
            send_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_send: got ch=%0d data=%h, want no send",
                         bus.active_ch, bus.tx_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.active_ch !== e.ch || bus.tx_data !== e.data) begin
                    bad++;
                    $display("FAIL send_word: got ch=%0d data=%h, want ch=%0d data=%h",
                             bus.active_ch, bus.tx_data, e.ch, e.data);
                end
            end
            lo_cnt = 2;
        end else if (lo_cnt > 0) begin
            lo_cnt--;
        end
        bus.tx_ready = (lo_cnt == 0);
        for (int i = 0; i < NUM_CH; i++) bus.fifo_empty[i] = (fq[i].size() == 0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic expect_word(input int ch, input logic [DATA_W-1:0] d);
        exp_t e;
        e.ch   = CH_W'(ch);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // kind 0: any fifo_rd; 1: send_cnt reaches target; 2: idle with nothing pending.
    task automatic wait_until(input int kind, input int target, input int bound, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if ((kind == 0 && bus.fifo_rd != '0) ||
                (kind == 1 && send_cnt >= target) ||
                (kind == 2 && !bus.busy && exp_q.size() == 0 && lo_cnt == 0)) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: timed out after %0d cycles, want event", name, bound);
        end
    endtask

    initial begin
        int t0;
        int base;
        int rd0;
        rst            = 1'b1;
        bus.rx_idle    = 1'b1;
        bus.ir_tx_idle = 1'b1;
        tick(3);
        check("rst_fifo_rd",   32'(bus.fifo_rd),   32'h0);
        check("rst_send",      32'(bus.send),      32'h0);
        check("rst_tx_data",   32'(bus.tx_data),   32'h0);
        check("rst_active_ch", 32'(bus.active_ch), 32'h0);
        check("rst_busy",      32'(bus.busy),      32'h0);

        // Single word after the post-reset guard.
        fq[0].push_back(8'hA5);
        expect_word(0, 8'hA5);
        tick(1);
        rst = 1'b0;
        t0  = cyc;
        wait_until(0, 0, 40, "t1_wait_rd");
        check("t1_rd_cycle", 32'(cyc - t0), 32'd17);
        check("t1_rd_vec",   32'(bus.fifo_rd), 32'h1);
        wait_until(1, 1, 10, "t1_wait_send");
        check("t1_send_cycle", 32'(cyc - t0), 32'd19);
        wait_until(2, 0, 40, "t1_wait_idle");
        check("t1_busy",      32'(bus.busy),      32'h0);
        check("t1_active_ch", 32'(bus.active_ch), 32'h0);

        // Round-robin: last grant is 0, so order is 1,2,3,0 then 1 before 0 again.
        fq[0].push_back(8'h11); fq[1].push_back(8'h22);
        fq[2].push_back(8'h33); fq[3].push_back(8'h44);
        expect_word(1, 8'h22); expect_word(2, 8'h33);
        expect_word(3, 8'h44); expect_word(0, 8'h11);
        wait_until(2, 0, 200, "rr_wait_idle");
        fq[0].push_back(8'h66); fq[1].push_back(8'h55);
        expect_word(1, 8'h55); expect_word(0, 8'h66);
        wait_until(2, 0, 100, "rr2_wait_idle");
        check("rr_last_ch", 32'(bus.active_ch), 32'h0);

        // Burst cap: ch2 holds 6 words, ch1 arrives mid-burst and cuts in after 4.
        for (int i = 0; i < 6; i++) fq[2].push_back(8'hC0 + 8'(i));
        for (int i = 0; i < 4; i++) expect_word(2, 8'hC0 + 8'(i));
        base = send_cnt;
        wait_until(1, base + 2, 60, "burst_wait_2nd");
        fq[1].push_back(8'h77);
        expect_word(1, 8'h77); expect_word(2, 8'hC4); expect_word(2, 8'hC5);
        wait_until(2, 0, 200, "burst_wait_idle");
        check("burst_total_sends", 32'(send_cnt - base), 32'd7);

        // Guard: 5 cycles of receive activity, then 16 quiet cycles before reading.
        bus.rx_idle = 1'b0;
        fq[0].push_back(8'h5A);
        expect_word(0, 8'h5A);
        tick(5);
        check("guard_no_rd", 32'(bus.fifo_rd), 32'h0);
        bus.rx_idle = 1'b1;
        t0 = cyc;
        wait_until(0, 0, 40, "guard_wait_rd");
        check("guard_rd_cycle", 32'(cyc - t0), 32'd17);
        wait_until(2, 0, 40, "guard_wait_idle");

        // Mid-burst abort: receiver wakes after the 2nd send.
        for (int i = 0; i < 4; i++) fq[0].push_back(8'hD0 + 8'(i));
        expect_word(0, 8'hD0); expect_word(0, 8'hD1);
        rd0  = rd_cnt;
        base = send_cnt;
        wait_until(1, base + 2, 60, "abort_wait_2nd");
        bus.rx_idle = 1'b0;
        tick(12);
        check("abort_reads",   32'(rd_cnt - rd0),   32'd2);
        check("abort_sends",   32'(send_cnt - base), 32'd2);
        check("abort_busy",    32'(bus.busy),        32'h0);

        // Reset while in WAIT_LO, then ch0 must be granted first again.
        expect_word(0, 8'hD2);
        bus.rx_idle = 1'b1;
        base = send_cnt;
        wait_until(1, base + 1, 60, "rst_wait_send");
        tick(1);
        check("rst_pre_busy", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        tick(1);
        check("midrst_fifo_rd", 32'(bus.fifo_rd), 32'h0);
        check("midrst_send",    32'(bus.send),    32'h0);
        check("midrst_busy",    32'(bus.busy),    32'h0);
        check("midrst_tx_data", 32'(bus.tx_data), 32'h0);
        fq[1].push_back(8'h88);
        expect_word(0, 8'hD3); expect_word(1, 8'h88);
        tick(1);
        rst = 1'b0;
        t0  = cyc;
        wait_until(0, 0, 40, "post_rst_wait_rd");
        check("post_rst_rd_cycle", 32'(cyc - t0), 32'd17);
        check("post_rst_rd_vec",   32'(bus.fifo_rd), 32'h1);
        wait_until(2, 0, 100, "post_rst_wait_idle");
        check("final_pending", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
